// File: rtl/dec_pkg.sv
// Shared types and helpers for the one-hot sequential decoder.
//
// Contents:
//   dec_state_t : replay FSM states (idle, strobe hold, idle gap)
//   cnt_width   : width of the hold/gap down-counter for given HOLD/GAP
//
// Configuration macro used by the decoder: DEC_ERR_EN (see onehot_decoder_seq).
package dec_pkg;

   // State names carry an S_ prefix so they do not collide with the
   // HOLD and GAP parameters of the decoder that imports this package.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HOLD = 2'd1,
      S_GAP  = 2'd2
   } dec_state_t;

   // Counter must be able to hold max(HOLD,GAP); never narrower than 1 bit.
   function automatic int cnt_width(input int hold, input int gap);
      int m;
      m = (hold > gap) ? hold : gap;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/dec_fifo2.sv
// Two-entry registered FIFO holding encoded indices for the decoder.
//
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   i_push     : write i_din (ignored when full)
//   i_pop      : drop the head entry (ignored when empty)
//   i_din      : data to write
//   o_head     : oldest entry, valid while !o_empty
//   o_full     : both entries occupied
//   o_empty    : no entries
module dec_fifo2 #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic [W-1:0] i_din,
   output logic [W-1:0] o_head,
   output logic         o_full,
   output logic         o_empty
);

   logic [W-1:0] r_mem [2];
   logic         r_wrPtr;
   logic         r_rdPtr;
   logic [1:0]   r_count;
   logic         w_doPush;
   logic         w_doPop;

   assign o_full   = (r_count == 2'd2);
   assign o_empty  = (r_count == 2'd0);
   assign o_head   = r_mem[r_rdPtr];
   assign w_doPush = i_push && !o_full;
   assign w_doPop  = i_pop && !o_empty;

   // Storage, pointers and occupancy. A simultaneous push and pop leaves
   // the occupancy unchanged while both pointers advance, keeping order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wrPtr  <= 1'b0;
         r_rdPtr  <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_doPush) begin
            r_mem[r_wrPtr] <= i_din;
            r_wrPtr        <= ~r_wrPtr;
         end
         if (w_doPop) begin
            r_rdPtr <= ~r_rdPtr;
         end
         if (w_doPush && !w_doPop) begin
            r_count <= r_count + 2'd1;
         end else if (w_doPop && !w_doPush) begin
            r_count <= r_count - 2'd1;
         end
      end
   end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Sequential decoder: accepts binary indices over a valid/ready stream,
// buffers up to two, and replays each as a one-hot strobe held for HOLD
// cycles followed by GAP all-zero cycles.
//
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   in_valid    : in_code holds a code
//   in_ready    : a code can be accepted this cycle (FIFO not full)
//   in_code     : encoded index
//   out_onehot  : decoded strobe, bit in_code set during HOLD
//   out_active  : high while in the HOLD state
//   busy        : FIFO non-empty or FSM not idle
//   err         : DEC_ERR_EN builds only; 1-cycle pulse on a dropped
//                 out-of-range code
//
// Macro DEC_ERR_EN: when defined, codes >= N_OUT are accepted but dropped
// and flagged on err; when undefined they are buffered and replayed as an
// all-zero strobe with out_active still high.
module onehot_decoder_seq
   import dec_pkg::*;
#(
   parameter int N_OUT = 4,
   parameter int IDX_W = 2,
   parameter int HOLD  = 4,
   parameter int GAP   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IDX_W-1:0] in_code,
   output logic [N_OUT-1:0] out_onehot,
   output logic             out_active,
   output logic             busy
`ifdef DEC_ERR_EN
   ,
   output logic             err
`endif
);

   localparam int            CW        = cnt_width(HOLD, GAP);
   localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD - 1);
   localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP - 1);

   dec_state_t       r_state;
   dec_state_t       w_stateNext;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cntNext;
   logic [N_OUT-1:0] r_onehot;
   logic [N_OUT-1:0] w_onehotNext;
   logic [N_OUT-1:0] w_decode;
   logic [IDX_W-1:0] w_head;
   logic             w_full;
   logic             w_empty;
   logic             w_accept;
   logic             w_push;
   logic             w_pop;

   assign in_ready   = !w_full;
   assign w_accept   = in_valid && in_ready;
   assign out_onehot = r_onehot;
   assign out_active = (r_state == S_HOLD);
   assign busy       = !w_empty || (r_state != S_IDLE);

`ifdef DEC_ERR_EN
   logic w_inRange;
   logic r_err;

   assign w_inRange = ({1'b0, in_code} < (IDX_W + 1)'(N_OUT));
   assign w_push    = w_accept && w_inRange;
   assign err       = r_err;

   // Out-of-range codes complete the handshake but never reach the FIFO;
   // the flag is raised for the single cycle after acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else begin
         r_err <= w_accept && !w_inRange;
      end
   end
`else
   assign w_push = w_accept;
`endif

   dec_fifo2 #(.W(IDX_W)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_din   (in_code),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Codes >= N_OUT match no output bit and so decode to all zeros.
   always_comb begin
      w_decode = '0;
      for (int i = 0; i < N_OUT; i++) begin
         w_decode[i] = (w_head == IDX_W'(i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_onehot <= '0;
      end else begin
         r_state  <= w_stateNext;
         r_cnt    <= w_cntNext;
         r_onehot <= w_onehotNext;
      end
   end

   // With GAP == 0 the end of a hold reloads straight from the FIFO so
   // consecutive strobes abut without a zero cycle between them.
   always_comb begin
      w_stateNext  = r_state;
      w_cntNext    = r_cnt;
      w_onehotNext = r_onehot;
      w_pop        = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_onehotNext = '0;
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_onehotNext = w_decode;
               w_cntNext    = HOLD_LOAD;
               w_stateNext  = S_HOLD;
            end
         end
         S_HOLD: begin
            if (r_cnt != '0) begin
               w_cntNext = r_cnt - CW'(1);
            end else if (GAP > 0) begin
               w_onehotNext = '0;
               w_cntNext    = GAP_LOAD;
               w_stateNext  = S_GAP;
            end else if (!w_empty) begin
               w_pop        = 1'b1;
               w_onehotNext = w_decode;
               w_cntNext    = HOLD_LOAD;
            end else begin
               w_onehotNext = '0;
               w_stateNext  = S_IDLE;
            end
         end
         S_GAP: begin
            w_onehotNext = '0;
            if (r_cnt != '0) begin
               w_cntNext = r_cnt - CW'(1);
            end else begin
               w_stateNext = S_IDLE;
            end
         end
         default: begin
            w_onehotNext = '0;
            w_cntNext    = '0;
            w_stateNext  = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed testbench for onehot_decoder_seq. Three instances share clock
// and reset: A (N_OUT=4, HOLD=4, GAP=1), B (HOLD=2, GAP=0) and
// C (N_OUT=3, HOLD=4, GAP=1) for out-of-range codes. Honours DEC_ERR_EN.
module tb_onehot_decoder_seq;

   logic       clk;
   logic       rst_n;
   int         testsRun;
   int         testsFailed;

   logic       validA, readyA, activeA, busyA, errA;
   logic [1:0] codeA;
   logic [3:0] onehotA;
   logic       validB, readyB, activeB, busyB, errB;
   logic [1:0] codeB;
   logic [3:0] onehotB;
   logic       validC, readyC, activeC, busyC, errC;
   logic [1:0] codeC;
   logic [2:0] onehotC;

   onehot_decoder_seq #(.N_OUT(4), .IDX_W(2), .HOLD(4), .GAP(1)) u_dutA (
      .clk(clk), .rst_n(rst_n), .in_valid(validA), .in_ready(readyA),
      .in_code(codeA), .out_onehot(onehotA), .out_active(activeA), .busy(busyA)
`ifdef DEC_ERR_EN
      , .err(errA)
`endif
   );

   onehot_decoder_seq #(.N_OUT(4), .IDX_W(2), .HOLD(2), .GAP(0)) u_dutB (
      .clk(clk), .rst_n(rst_n), .in_valid(validB), .in_ready(readyB),
      .in_code(codeB), .out_onehot(onehotB), .out_active(activeB), .busy(busyB)
`ifdef DEC_ERR_EN
      , .err(errB)
`endif
   );

   onehot_decoder_seq #(.N_OUT(3), .IDX_W(2), .HOLD(4), .GAP(1)) u_dutC (
      .clk(clk), .rst_n(rst_n), .in_valid(validC), .in_ready(readyC),
      .in_code(codeC), .out_onehot(onehotC), .out_active(activeC), .busy(busyC)
`ifdef DEC_ERR_EN
      , .err(errC)
`endif
   );

`ifndef DEC_ERR_EN
   assign errA = 1'b0;
   assign errB = 1'b0;
   assign errC = 1'b0;
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      validA = 1'b1;
      codeA  = 2'd2;
      repeat (3) step();
      testsRun++;
      if (readyA !== 1'b1 || onehotA !== 4'b0000 || busyA !== 1'b0 || activeA !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_values: ready=%b onehot=%b busy=%b active=%b, need 1 0000 0 0",
                  readyA, onehotA, busyA, activeA);
      end
      rst_n = 1'b1;
      step();
      validA = 1'b0;
      testsRun++;
      if (onehotA !== 4'b0000 || busyA !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL reset_accept: onehot=%b busy=%b, need 0000 1", onehotA, busyA);
      end
      for (int k = 1; k <= 4; k++) begin
         step();
         testsRun++;
         if (onehotA !== 4'b0100 || activeA !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_hold%0d: onehot=%b active=%b, need 0100 1", k, onehotA, activeA);
         end
      end
      step();
      testsRun++;
      if (onehotA !== 4'b0000 || activeA !== 1'b0 || busyA !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL reset_gap: onehot=%b active=%b busy=%b, need 0000 0 1",
                  onehotA, activeA, busyA);
      end
      step();
      testsRun++;
      if (onehotA !== 4'b0000 || busyA !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_idle: onehot=%b busy=%b, need 0000 0", onehotA, busyA);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] expOh [18];
      expOh = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0,
                4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0,
                4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0};
      validA = 1'b1;
      codeA  = 2'd0;
      step();
      codeA = 2'd1;
      for (int i = 0; i < 18; i++) begin
         step();
         if (i == 0) begin
            codeA = 2'd3;
            testsRun++;
            if (readyA !== 1'b1) begin
               testsFailed++;
               $display("[TB] FAIL b2b_ready_one: got %b, need 1", readyA);
            end
         end
         if (i == 1) begin
            validA = 1'b0;
            testsRun++;
            if (readyA !== 1'b0) begin
               testsFailed++;
               $display("[TB] FAIL b2b_ready_full: got %b, need 0", readyA);
            end
         end
         testsRun++;
         if (onehotA !== expOh[i] || activeA !== (expOh[i] != 4'h0)) begin
            testsFailed++;
            $display("[TB] FAIL b2b_cycle%0d: onehot=%b active=%b, need %b %b",
                     i, onehotA, activeA, expOh[i], (expOh[i] != 4'h0));
         end
         testsRun++;
         if (busyA !== (i != 17)) begin
            testsFailed++;
            $display("[TB] FAIL b2b_busy%0d: got %b, need %b", i, busyA, (i != 17));
         end
      end
   endtask

   task automatic test_gap_zero();
      logic [3:0] expOh [5];
      expOh  = '{4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0000};
      validB = 1'b1;
      codeB  = 2'd1;
      step();
      codeB = 2'd2;
      step();
      validB = 1'b0;
      for (int i = 0; i < 5; i++) begin
         testsRun++;
         if (onehotB !== expOh[i] || activeB !== (i < 4)) begin
            testsFailed++;
            $display("[TB] FAIL gap0_cycle%0d: onehot=%b active=%b, need %b %b",
                     i, onehotB, activeB, expOh[i], (i < 4));
         end
         step();
      end
   endtask

   task automatic test_reset_mid();
      validA = 1'b1;
      codeA  = 2'd3;
      step();
      codeA = 2'd0;
      step();
      validA = 1'b0;
      step();
      testsRun++;
      if (onehotA !== 4'b1000 || busyA !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL mid_hold2: onehot=%b busy=%b, need 1000 1", onehotA, busyA);
      end
      #2 rst_n = 1'b0;
      #1;
      testsRun++;
      if (onehotA !== 4'b0000 || activeA !== 1'b0 || busyA !== 1'b0 || readyA !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL mid_abort: onehot=%b active=%b busy=%b ready=%b, need 0000 0 0 1",
                  onehotA, activeA, busyA, readyA);
      end
      repeat (2) step();
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         testsRun++;
         if (onehotA !== 4'b0000 || busyA !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL mid_after%0d: onehot=%b busy=%b, need 0000 0", k, onehotA, busyA);
         end
      end
   endtask

   task automatic test_push_pop();
      validA = 1'b1;
      codeA  = 2'd2;
      step();
      codeA = 2'd1;
      step();
      validA = 1'b0;
      testsRun++;
      if (readyA !== 1'b1 || onehotA !== 4'b0100) begin
         testsFailed++;
         $display("[TB] FAIL pushpop_same: ready=%b onehot=%b, need 1 0100", readyA, onehotA);
      end
      repeat (4) step();
      testsRun++;
      if (onehotA !== 4'b0000 || busyA !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL pushpop_gap: onehot=%b busy=%b, need 0000 1", onehotA, busyA);
      end
      repeat (2) step();
      testsRun++;
      if (onehotA !== 4'b0010) begin
         testsFailed++;
         $display("[TB] FAIL pushpop_order: onehot=%b, need 0010", onehotA);
      end
      repeat (8) step();
   endtask

   task automatic test_out_of_range();
      validC = 1'b1;
      codeC  = 2'd3;
      step();
`ifdef DEC_ERR_EN
      codeC = 2'd2;
      testsRun++;
      if (errC !== 1'b1 || readyC !== 1'b1 || busyC !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL oor_err: err=%b ready=%b busy=%b, need 1 1 0", errC, readyC, busyC);
      end
      step();
      validC = 1'b0;
      testsRun++;
      if (errC !== 1'b0 || onehotC !== 3'b000) begin
         testsFailed++;
         $display("[TB] FAIL oor_err_pulse: err=%b onehot=%b, need 0 000", errC, onehotC);
      end
      step();
      testsRun++;
      if (onehotC !== 3'b100 || activeC !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL oor_next: onehot=%b active=%b, need 100 1", onehotC, activeC);
      end
`else
      validC = 1'b0;
      testsRun++;
      if (busyC !== 1'b1 || activeC !== 1'b0 || errC !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL oor_buffered: busy=%b active=%b, need 1 0", busyC, activeC);
      end
      for (int k = 1; k <= 4; k++) begin
         step();
         testsRun++;
         if (activeC !== 1'b1 || onehotC !== 3'b000) begin
            testsFailed++;
            $display("[TB] FAIL oor_hold%0d: active=%b onehot=%b, need 1 000", k, activeC, onehotC);
         end
      end
      step();
      testsRun++;
      if (activeC !== 1'b0 || busyC !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL oor_gap: active=%b busy=%b, need 0 1", activeC, busyC);
      end
      step();
      testsRun++;
      if (busyC !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL oor_idle: busy=%b, need 0", busyC);
      end
`endif
      repeat (8) step();
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      rst_n  = 1'b0;
      validA = 1'b0; codeA = 2'd0;
      validB = 1'b0; codeB = 2'd0;
      validC = 1'b0; codeC = 2'd0;
      test_reset();
      test_back_to_back();
      test_gap_zero();
      test_reset_mid();
      test_push_pop();
      test_out_of_range();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
